// File: rtl/liteic_pkg.sv
// ----------------------------------------------------------------------------
// liteic_pkg
// Shared AXI4-Lite constants and state types for the liteic interconnect and
// its endpoints.
//   AXI_ADDR_WIDTH / AXI_DATA_WIDTH : default bus widths
//   AXI_RESP_OKAY / AXI_RESP_DECERR : BRESP/RRESP encodings
//   axil_wr_state_e / axil_rd_state_e : endpoint channel FSM states
// ----------------------------------------------------------------------------
package liteic_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic {WR_COLLECT, WR_RESP} axil_wr_state_e;
   typedef enum logic {RD_IDLE, RD_RESP}    axil_rd_state_e;

endpackage

// File: rtl/liteic_sram_1r1w.sv
// ----------------------------------------------------------------------------
// liteic_sram_1r1w
// Behavioural one-read / one-write SRAM with byte enables, written so that a
// synthesis tool can map it onto a technology block RAM.
//   clk_i   : clock, rising edge
//   we_i    : write enable (qualified per byte by wbe_i)
//   waddr_i : write word index
//   wdata_i : write data
//   wbe_i   : byte enables
//   re_i    : read enable; rdata_o updates on the following edge
//   raddr_i : read word index
//   rdata_o : registered read data, holds its value while re_i is low
// A read and a write to the same word in one cycle return the old contents.
// ----------------------------------------------------------------------------
module liteic_sram_1r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [$clog2(DEPTH)-1:0]  waddr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   wbe_i,
   input  logic                      re_i,
   input  logic [$clog2(DEPTH)-1:0]  raddr_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset on purpose; resetting it would turn a block
   // RAM into thousands of flops.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (wbe_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      // NOTE: non-blocking assignment makes the read sample the array before
      // this edge's write lands, which is exactly the read-first behaviour.
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/liteic_axil_sram_slave.sv
// ----------------------------------------------------------------------------
// liteic_axil_sram_slave
// AXI4-Lite slave endpoint fronting a word-addressed SRAM on one interconnect
// slave slot. Read and write channels run independently, each with a single
// outstanding transaction. Addresses outside the window answer DECERR.
//   clk_i, rst_i               : clock and synchronous active-high reset
//   aw_* / w_* / b_*           : write address, write data, write response
//   ar_* / r_*                 : read address, read data/response
//   aw_qos, ar_qos             : accepted and ignored
// All ready/valid outputs are registered.
// ----------------------------------------------------------------------------
module liteic_axil_sram_slave
   import liteic_pkg::*;
#(
   parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    MEM_WORDS  = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [3:0]              aw_qos,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [3:0]              ar_qos,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_valid,
   input  logic                    r_ready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int BYTE_W     = $clog2(STRB_WIDTH);
   localparam int IDX_W      = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] WINDOW_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * STRB_WIDTH);

   axil_wr_state_e wr_state;
   axil_rd_state_e rd_state;

   logic                  aw_full, w_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  rd_hit_q;
   logic [DATA_WIDTH-1:0] sram_rdata;

   logic unused_qos;
   assign unused_qos = ^{aw_qos, ar_qos};

   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = aw_valid && aw_ready;
   assign w_hs  = w_valid  && w_ready;
   assign ar_hs = ar_valid && ar_ready;

   // The commit may use a request arriving this very cycle, so AW and W
   // landing together respond one cycle later without first filling a latch.
   logic [ADDR_WIDTH-1:0] wr_addr, wr_offset, ar_offset;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic                  wr_commit, wr_hit, ar_hit;

   assign wr_addr   = aw_full ? aw_addr_q : aw_addr;
   assign wr_data   = w_full  ? w_data_q  : w_data;
   assign wr_strb   = w_full  ? w_strb_q  : w_strb;
   assign wr_commit = (wr_state == WR_COLLECT) && (aw_full || aw_hs) && (w_full || w_hs);

   // The unsigned subtraction wraps addresses below the base far above the
   // window, so one compare covers both sides.
   assign wr_offset = wr_addr - BASE_ADDR;
   assign ar_offset = ar_addr - BASE_ADDR;
   assign wr_hit    = {1'b0, wr_offset} < WINDOW_BYTES;
   assign ar_hit    = {1'b0, ar_offset} < WINDOW_BYTES;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_state  <= WR_COLLECT;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         aw_ready  <= 1'b0;
         w_ready   <= 1'b0;
         b_valid   <= 1'b0;
         b_resp    <= '0;
      end else begin
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         case (wr_state)
            WR_COLLECT: begin
               if (aw_hs) begin
                  aw_full   <= 1'b1;
                  aw_addr_q <= aw_addr;
               end
               if (w_hs) begin
                  w_full   <= 1'b1;
                  w_data_q <= w_data;
                  w_strb_q <= w_strb;
               end
               if (wr_commit) begin
                  b_valid  <= 1'b1;
                  b_resp   <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
                  wr_state <= WR_RESP;
               end else begin
                  aw_ready <= !(aw_full || aw_hs);
                  w_ready  <= !(w_full  || w_hs);
               end
            end
            WR_RESP: begin
               if (b_ready) begin
                  b_valid  <= 1'b0;
                  aw_full  <= 1'b0;
                  w_full   <= 1'b0;
                  wr_state <= WR_COLLECT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state <= RD_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_resp   <= '0;
         rd_hit_q <= 1'b0;
      end else begin
         ar_ready <= 1'b0;
         case (rd_state)
            RD_IDLE: begin
               if (ar_hs) begin
                  r_valid  <= 1'b1;
                  r_resp   <= ar_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
                  rd_hit_q <= ar_hit;
                  rd_state <= RD_RESP;
               end else begin
                  ar_ready <= 1'b1;
               end
            end
            RD_RESP: begin
               if (r_ready) begin
                  r_valid  <= 1'b0;
                  rd_hit_q <= 1'b0;
                  rd_state <= RD_IDLE;
               end
            end
         endcase
      end
   end

   // The SRAM output register is not reset and holds its last word; gating it
   // with the registered hit flag gives zero on a miss, when idle and after reset.
   assign r_data = rd_hit_q ? sram_rdata : '0;

   liteic_sram_1r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_WORDS)
   ) u_sram (
      .clk_i   (clk_i),
      .we_i    (wr_commit && wr_hit),
      .waddr_i (wr_offset[IDX_W+BYTE_W-1:BYTE_W]),
      .wdata_i (wr_data),
      .wbe_i   (wr_strb),
      .re_i    (ar_hs && ar_hit),
      .raddr_i (ar_offset[IDX_W+BYTE_W-1:BYTE_W]),
      .rdata_o (sram_rdata)
   );

endmodule
